mmio_responder: RTL and testbench

- Memory-mapped I/O target for the Riscv151 core's load/store path.
- Services CPU accesses in the 0x8000_xxxx region: UART status, RX data, TX data, cycle counter, instruction counter and counter clear.
- Sits between the core's MEM stage and the on-chip uart; buffers received bytes in a small RX FIFO.
- Returns read data with the same one-cycle latency as dmem, so WB-stage muxing is unchanged.

---
 rtl/mmio_pkg.sv | 18 +
 rtl/byte_fifo.sv | 62 ++++++
 rtl/mmio_responder.sv | 120 ++++++++++++
 tb/tb_mmio_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the 0x8000_xxxx MMIO region: region tag, register offsets
// and control-register bit positions.
package mmio_pkg;

    localparam logic [3:0] MMIO_REGION = 4'b1000;

    localparam logic [7:0] OFF_UART_CTRL = 8'h00;
    localparam logic [7:0] OFF_UART_RX   = 8'h04;
    localparam logic [7:0] OFF_UART_TX   = 8'h08;
    localparam logic [7:0] OFF_CYC       = 8'h10;
    localparam logic [7:0] OFF_INST      = 8'h14;
    localparam logic [7:0] OFF_CNT_CLR   = 8'h18;

    localparam int CTRL_TX_RDY_BIT  = 0;
    localparam int CTRL_RX_AVAIL_BIT = 1;
    localparam int CTRL_TX_OVR_BIT  = 2;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered occupancy count; DEPTH must be a power of 2.
// Pushes into a full FIFO and pops from an empty one are ignored.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en, pop_en;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target for the core's MEM stage: UART TX/RX registers, RX byte FIFO and
// cycle/instruction counters, with registered one-cycle read data like dmem.
module mmio_responder #(
    parameter int         RX_FIFO_DEPTH = 4,
    parameter logic [3:0] MMIO_REGION   = mmio_pkg::MMIO_REGION
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_wdata,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    import mmio_pkg::*;

    logic        sel, rd_sel, wr_sel;
    logic [7:0]  off;
    logic [31:0] rd_val;
    logic        cnt_clr;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;

    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_ovr_q, tx_ovr_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] inst_q, inst_d;

    assign sel     = (req_addr[31:28] == MMIO_REGION);
    assign off     = req_addr[7:0];
    assign rd_sel  = sel & req_rd;
    assign wr_sel  = sel & req_wr;
    assign cnt_clr = wr_sel && (off == OFF_CNT_CLR);

    assign rx_ready  = ~fifo_full;
    assign fifo_push = rx_valid & rx_ready;
    assign fifo_pop  = rd_sel && (off == OFF_UART_RX) && !fifo_empty;

    byte_fifo #(
        .DEPTH(RX_FIFO_DEPTH),
        .WIDTH(8)
    ) u_rx_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .din  (rx_data),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_UART_CTRL: begin
                rd_val[CTRL_TX_RDY_BIT]   = tx_ready & ~tx_valid_q;
                rd_val[CTRL_RX_AVAIL_BIT] = ~fifo_empty;
                rd_val[CTRL_TX_OVR_BIT]   = tx_ovr_q;
            end
            OFF_UART_RX: if (!fifo_empty) rd_val = {24'b0, fifo_dout};
            OFF_CYC:     rd_val = cyc_q;
            OFF_INST:    rd_val = inst_q;
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        rdata_d    = rd_sel ? rd_val : rdata_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_ovr_d   = tx_ovr_q;
        if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
        // A byte is accepted only into an empty TX slot; otherwise flag the loss.
        if (wr_sel && (off == OFF_UART_TX)) begin
            if (!tx_valid_q) begin
                tx_valid_d = 1'b1;
                tx_data_d  = req_wdata[7:0];
            end else begin
                tx_ovr_d = 1'b1;
            end
        end
        if (rd_sel && (off == OFF_UART_CTRL)) tx_ovr_d = 1'b0;
        cyc_d  = cnt_clr ? '0 : cyc_q + 32'd1;
        inst_d = cnt_clr ? '0 : inst_q + {31'b0, inst_retire};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_ovr_q   <= 1'b0;
            cyc_q      <= '0;
            inst_q     <= '0;
        end else begin
            rdata_q    <= rdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_ovr_q   <= tx_ovr_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
        end
    end

    assign rdata    = rdata_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the register map.
module tb_mmio_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr;
    logic        req_rd, req_wr;
    logic [31:0] req_wdata;
    logic        inst_retire;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_q[$];
    logic        m_txv;
    logic [7:0]  m_txd;
    logic        m_ovr;
    logic [31:0] m_cyc, m_inst, m_rdata;

    mmio_responder #(.RX_FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_addr   (req_addr),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_wdata  (req_wdata),
        .inst_retire(inst_retire),
        .rdata      (rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) assert (!(req_rd && req_wr)) else $error("FAIL rd_wr_overlap: req_rd and req_wr together");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q.delete();
        m_txv = 1'b0; m_txd = 8'h00; m_ovr = 1'b0;
        m_cyc = 32'd0; m_inst = 32'd0; m_rdata = 32'd0;
    endtask

    task automatic drive_idle(input logic txr);
        req_rd = 1'b0; req_wr = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        inst_retire = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = txr;
    endtask

    // Drive one request cycle (called at a negedge), advance the model, return at the next negedge.
    task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic retire, input logic rxv, input logic [7:0] rxd, input logic txr);
        logic       sel, room, old_txv, clr;
        logic [7:0] off;
        req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wd;
        inst_retire = retire; rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        sel     = (addr[31:28] == 4'h8);
        off     = addr[7:0];
        room    = (m_q.size() < DEPTH);
        old_txv = m_txv;
        clr     = sel && wr && (off == 8'h18);
        if (sel && rd) begin
            case (off)
                8'h00: begin
                    m_rdata = {29'b0, m_ovr, (m_q.size() != 0), txr & ~old_txv};
                    m_ovr = 1'b0;
                end
                8'h04:   m_rdata = (m_q.size() != 0) ? {24'b0, m_q.pop_front()} : 32'd0;
                8'h10:   m_rdata = m_cyc;
                8'h14:   m_rdata = m_inst;
                default: m_rdata = 32'd0;
            endcase
        end
        if (old_txv && txr) m_txv = 1'b0;
        if (sel && wr && (off == 8'h08)) begin
            if (!old_txv) begin m_txv = 1'b1; m_txd = wd[7:0]; end
            else m_ovr = 1'b1;
        end
        if (rxv && room) m_q.push_back(rxd);
        m_cyc  = clr ? 32'd0 : m_cyc + 32'd1;
        m_inst = clr ? 32'd0 : m_inst + 32'(retire);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle(1'b1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        step(1, 0, 32'h8000_0000, 0, 0, 0, 0, 1);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL idle_ctrl: got %h want 1", rdata); end
        checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL idle_ctrl_model: got %h want %h", rdata, m_rdata); end
    endtask

    task automatic test_tx();
        step(0, 1, 32'h8000_0008, 32'h1234_5641, 0, 0, 0, 0);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_load_valid: got %b want 1", tx_valid); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL tx_load_data: got %h want 41", tx_data); end
        step(0, 1, 32'h8000_0008, 32'h0000_0099, 0, 0, 0, 0);
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL tx_drop_data: got %h want 41", tx_data); end
        step(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL tx_overrun_set: got %h want 4", rdata); end
        step(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL tx_overrun_clear: got %h want 0", rdata); end
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_hold_valid: got %b want 1", tx_valid); end
        step(0, 0, 32'd0, 0, 0, 0, 0, 1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_handshake_drop: got %b want 0", tx_valid); end
        step(1, 0, 32'h8000_0000, 0, 0, 0, 0, 1);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL tx_ready_again: got %h want 1", rdata); end
    endtask

    task automatic test_rx_fill();
        logic [7:0] exp_b [6];
        exp_b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'd0, 0, 0, 1, 8'(8'hA1 + i), 0);
            checks++;
            if (rx_ready !== (i < 3)) begin errors++; $display("FAIL rx_fill_ready[%0d]: got %b want %b", i, rx_ready, (i < 3)); end
        end
        step(0, 0, 32'd0, 0, 0, 1, 8'hA5, 0);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_hold: got %b want 0", rx_ready); end
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 32'h8000_0004, 0, 0, (i < 2), 8'hA5, 0);
            checks++;
            if (rdata !== {24'b0, exp_b[i]}) begin errors++; $display("FAIL rx_read[%0d]: got %h want %h", i, rdata, exp_b[i]); end
        end
        step(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rx_empty_ctrl: got %h want 0", rdata); end
    endtask

    task automatic test_push_pop();
        step(0, 0, 32'd0, 0, 0, 1, 8'hC1, 0);
        step(0, 0, 32'd0, 0, 0, 1, 8'hC2, 0);
        step(1, 0, 32'h8000_0004, 0, 0, 1, 8'hB7, 0);
        checks++; if (rdata !== 32'hC1) begin errors++; $display("FAIL pp_first: got %h want c1", rdata); end
        step(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL pp_ctrl: got %h want 2", rdata); end
        step(1, 0, 32'h8000_0004, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'hC2) begin errors++; $display("FAIL pp_second: got %h want c2", rdata); end
        step(1, 0, 32'h8000_0004, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'hB7) begin errors++; $display("FAIL pp_third: got %h want b7", rdata); end
        step(1, 0, 32'h8000_0004, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL pp_empty: got %h want 0", rdata); end
    endtask

    task automatic test_counters();
        step(0, 1, 32'h8000_0018, 32'hDEAD_BEEF, 1, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 32'd0, 0, ((i % 5) < 2), 0, 0, 0);
        step(1, 0, 32'h8000_0010, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'd100) begin errors++; $display("FAIL cyc_count: got %0d want 100", rdata); end
        step(1, 0, 32'h8000_0014, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'd40) begin errors++; $display("FAIL inst_count: got %0d want 40", rdata); end
        step(0, 1, 32'h8000_0018, 32'h0, 1, 0, 0, 0);
        step(1, 0, 32'h8000_0014, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL inst_clear: got %0d want 0", rdata); end
        step(1, 0, 32'h8000_0010, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL cyc_clear: got %0d want 1", rdata); end
        step(1, 0, 32'h0000_0010, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL unselected_hold: got %0d want 1", rdata); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 32'h8000_0008, 32'h5A, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 32'd0, 0, 0, 1, 8'(8'hD0 + i), 0);
        step(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0);
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL mid_pre_ctrl: got %h want 2", rdata); end
        drive_idle(1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b want 0", tx_valid); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_rdata: got %h want 0", rdata); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL mid_rx_ready: got %b want 1", rx_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 0, 32'h8000_0004, 0, 0, 0, 0, 1);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mid_fifo_empty: got %h want 0", rdata); end
        step(1, 0, 32'h8000_0000, 0, 0, 0, 0, 1);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL mid_ctrl: got %h want 1", rdata); end
    endtask

    task automatic test_random();
        logic [7:0]  offs [9];
        logic [31:0] addr;
        int          kind;
        offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C, 8'hFF};
        for (int n = 0; n < 400; n++) begin
            addr = {4'h8, 20'($urandom), offs[$urandom_range(0, 8)]};
            if ($urandom_range(0, 4) == 0) addr[31:28] = 4'($urandom_range(0, 7));
            kind = $urandom_range(0, 3);
            step(kind == 1, kind == 2, addr, $urandom, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rdata, m_rdata); end
            checks++; if (tx_valid !== m_txv) begin errors++; $display("FAIL rnd_tx_valid[%0d]: got %b want %b", n, tx_valid, m_txv); end
            checks++; if (tx_data !== m_txd) begin errors++; $display("FAIL rnd_tx_data[%0d]: got %h want %h", n, tx_data, m_txd); end
            checks++;
            if (rx_ready !== (m_q.size() < DEPTH)) begin
                errors++; $display("FAIL rnd_rx_ready[%0d]: got %b want %b", n, rx_ready, (m_q.size() < DEPTH));
            end
        end
    endtask

    initial begin
        drive_idle(1'b1);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        test_reset();
        test_tx();
        test_rx_fill();
        test_push_pop();
        test_counters();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
